ob_mk_queue: RTL and testbench

- Per-side FIFO of resting market orders (one instance for market buy, one for market sell).
- Sits directly upstream of the market/limit trade-selection stage and drives its head_vld_r/head_r inputs.
- Accepts new market orders from the command decoder.
- Applies the trade decision fed back each cycle: pops a fully consumed head, or overwrites the head quantity with the trade remainder.

---
 rtl/ob_pkg.sv | 16 +
 rtl/ob_mk_queue_if.sv | 37 +++
 rtl/ob_mk_queue.sv | 90 +++++++++
 tb/tb_ob_mk_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// ob_pkg: shared order-book types.
//   uid_t       order identifier
//   price_t     limit price (unused for market orders but carried through)
//   quantity_t  order quantity
//   table_t     one resting order {uid, price, quantity}
package ob_pkg;
    typedef logic [7:0]  uid_t;
    typedef logic [15:0] price_t;
    typedef logic [15:0] quantity_t;

    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t quantity;
    } table_t;
endpackage

// File: rtl/ob_mk_queue_if.sv
// ob_mk_queue_if: bundle between the command decoder / trade-selection stage
// (master) and one market-order queue (slave).
//   in_vld/in_rdy/in        new order push; transfer when in_vld & in_rdy at posedge
//   head_vld_r/head_r       registered head of queue
//   upd_vld/upd_consumed/
//   upd_remainder           trade-decision feedback for the current head
//   cnt_r/full_r/empty_r    occupancy status
//   err_r                   one-cycle pulse on an update while empty
// Handshake: a push happens on a rising edge where in_vld and in_rdy are both
// high; in_rdy does not depend on in_vld, and in_vld while !in_rdy is dropped.
interface ob_mk_queue_if #(
    parameter int N     = 16,
    parameter int W_CNT = $clog2(N) + 1
);
    logic              in_vld;
    logic              in_rdy;
    ob_pkg::table_t    in;
    logic              head_vld_r;
    ob_pkg::table_t    head_r;
    logic              upd_vld;
    logic              upd_consumed;
    ob_pkg::quantity_t upd_remainder;
    logic [W_CNT-1:0]  cnt_r;
    logic              full_r;
    logic              empty_r;
    logic              err_r;

    modport master (
        output in_vld, in, upd_vld, upd_consumed, upd_remainder,
        input  in_rdy, head_vld_r, head_r, cnt_r, full_r, empty_r, err_r
    );

    modport slave (
        input  in_vld, in, upd_vld, upd_consumed, upd_remainder,
        output in_rdy, head_vld_r, head_r, cnt_r, full_r, empty_r, err_r
    );
endinterface

// File: rtl/ob_mk_queue.sv
// ob_mk_queue: per-side FIFO of resting market orders. Presents a registered
// head to the trade-selection stage and applies its feedback: pop a consumed
// head, or overwrite the head quantity with the trade remainder.
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   ob_mk_queue_if.slave (push, head, update feedback, status)
// N must be a power of two (>= 2) so pointers wrap by natural overflow.
module ob_mk_queue #(
    parameter int N     = 16,
    parameter int W_CNT = $clog2(N) + 1
) (
    input logic          clk,
    input logic          rst,
    ob_mk_queue_if.slave bus
);
    localparam int W_PTR = $clog2(N);

    ob_pkg::table_t   mem_q [N];
    logic [W_PTR-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [W_PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             head_vld_q, head_vld_d;
    ob_pkg::table_t   head_q, head_d;
    logic             full_q, empty_q, err_q, err_d;
    logic             push, upd_live, pop, part;

    always_comb begin
        push       = bus.in_vld & ~full_q;
        upd_live   = bus.upd_vld & head_vld_q;
        // A zero remainder means nothing is left resting: treat as a pop.
        pop        = upd_live & (bus.upd_consumed | (bus.upd_remainder == '0));
        part       = upd_live & ~pop;
        err_d      = bus.upd_vld & ~head_vld_q;

        rd_ptr_nxt = rd_ptr_q + W_PTR'(1);
        rd_ptr_d   = pop  ? rd_ptr_nxt : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + W_PTR'(1) : wr_ptr_q;
        cnt_d      = cnt_q + W_CNT'(push) - W_CNT'(pop);
        head_vld_d = (cnt_d != '0);

        head_d = head_q;
        if (pop) begin
            // With one entry left the successor is not in memory yet; take it
            // straight from the incoming order.
            if (cnt_q > W_CNT'(1)) head_d = mem_q[rd_ptr_nxt];
            else if (push)         head_d = bus.in;
        end else if (part) begin
            head_d.quantity = bus.upd_remainder;
        end else if (!head_vld_q && push) begin
            head_d = bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            full_q     <= (cnt_d == W_CNT'(N));
            empty_q    <= (cnt_d == '0);
            err_q      <= err_d;
        end
    end

    // Storage carries no reset. A push and a partial fill never hit the same
    // slot: partial needs cnt >= 1 and push needs !full, so wr_ptr != rd_ptr.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in;
        if (part) mem_q[rd_ptr_q].quantity <= bus.upd_remainder;
    end

    assign bus.in_rdy     = ~full_q;
    assign bus.head_vld_r = head_vld_q;
    assign bus.head_r     = head_q;
    assign bus.cnt_r      = cnt_q;
    assign bus.full_r     = full_q;
    assign bus.empty_r    = empty_q;
    assign bus.err_r      = err_q;
endmodule

// File: tb/tb_ob_mk_queue.sv
module tb_ob_mk_queue;
    localparam int N     = 16;
    localparam int W_CNT = $clog2(N) + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ob_mk_queue_if #(.N(N), .W_CNT(W_CNT)) bus();

    ob_mk_queue #(.N(N), .W_CNT(W_CNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The queue contents as a list of orders; the head is simply element 0.
    ob_pkg::table_t mq[$];
    logic           exp_err;

    task automatic model_step();
        logic can_push;
        exp_err  = 1'b0;
        can_push = bus.in_vld && (mq.size() < N);
        if (bus.upd_vld) begin
            if (mq.size() == 0) exp_err = 1'b1;
            else if (bus.upd_consumed || bus.upd_remainder == 0) void'(mq.pop_front());
            else mq[0].quantity = bus.upd_remainder;
        end
        if (can_push) mq.push_back(bus.in);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        bus.in_vld        = 1'b0;
        bus.in            = '0;
        bus.upd_vld       = 1'b0;
        bus.upd_consumed  = 1'b0;
        bus.upd_remainder = '0;
    endtask

    task automatic drive_push(input int uid, input int price, input int qty);
        bus.in_vld      = 1'b1;
        bus.in.uid      = 8'(uid);
        bus.in.price    = 16'(price);
        bus.in.quantity = 16'(qty);
    endtask

    task automatic drive_upd(input logic consumed, input int rem);
        bus.upd_vld       = 1'b1;
        bus.upd_consumed  = consumed;
        bus.upd_remainder = 16'(rem);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        mq.delete();
        exp_err = 1'b0;
        #12;
        checks += 6;
        if (bus.head_vld_r !== 1'b0) begin errors++; $display("FAIL reset_head_vld: got %0b expected 0", bus.head_vld_r); end
        if (bus.cnt_r !== '0)        begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.cnt_r); end
        if (bus.empty_r !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %0b expected 1", bus.empty_r); end
        if (bus.full_r !== 1'b0)     begin errors++; $display("FAIL reset_full: got %0b expected 0", bus.full_r); end
        if (bus.err_r !== 1'b0)      begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err_r); end
        if (bus.in_rdy !== 1'b1)     begin errors++; $display("FAIL reset_in_rdy: got %0b expected 1", bus.in_rdy); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_push_empty();
        drive_push(5, 100, 10);
        tick();
        drive_idle();
        checks += 5;
        if (bus.head_vld_r !== 1'b1)       begin errors++; $display("FAIL push_empty_vld: got %0b expected 1", bus.head_vld_r); end
        if (bus.head_r.uid !== 8'd5)       begin errors++; $display("FAIL push_empty_uid: got %0d expected 5", bus.head_r.uid); end
        if (bus.head_r.quantity !== 16'd10) begin errors++; $display("FAIL push_empty_qty: got %0d expected 10", bus.head_r.quantity); end
        if (bus.cnt_r !== W_CNT'(1))       begin errors++; $display("FAIL push_empty_cnt: got %0d expected 1", bus.cnt_r); end
        if (bus.empty_r !== 1'b0)          begin errors++; $display("FAIL push_empty_empty: got %0b expected 0", bus.empty_r); end
    endtask

    task automatic test_partial_fill();
        drive_upd(1'b0, 4);
        tick();
        drive_idle();
        checks += 3;
        if (bus.head_r.quantity !== 16'd4) begin errors++; $display("FAIL partial_qty: got %0d expected 4", bus.head_r.quantity); end
        if (bus.head_r.uid !== 8'd5)       begin errors++; $display("FAIL partial_uid: got %0d expected 5", bus.head_r.uid); end
        if (bus.cnt_r !== W_CNT'(1))       begin errors++; $display("FAIL partial_cnt: got %0d expected 1", bus.cnt_r); end
        drive_upd(1'b0, 0);
        tick();
        drive_idle();
        checks += 3;
        if (bus.head_vld_r !== 1'b0) begin errors++; $display("FAIL zero_rem_vld: got %0b expected 0", bus.head_vld_r); end
        if (bus.cnt_r !== '0)        begin errors++; $display("FAIL zero_rem_cnt: got %0d expected 0", bus.cnt_r); end
        if (bus.err_r !== 1'b0)      begin errors++; $display("FAIL zero_rem_err: got %0b expected 0", bus.err_r); end
    endtask

    task automatic test_full_wrap();
        for (int i = 1; i <= N; i++) begin
            drive_push(i, 200 + i, 50 + i);
            tick();
        end
        // 17th push while full must be dropped
        drive_push(99, 999, 99);
        checks += 3;
        if (bus.full_r !== 1'b1)      begin errors++; $display("FAIL full_flag: got %0b expected 1", bus.full_r); end
        if (bus.in_rdy !== 1'b0)      begin errors++; $display("FAIL full_in_rdy: got %0b expected 0", bus.in_rdy); end
        if (bus.cnt_r !== W_CNT'(N))  begin errors++; $display("FAIL full_cnt: got %0d expected %0d", bus.cnt_r, N); end
        tick();
        drive_idle();
        checks += 2;
        if (bus.cnt_r !== W_CNT'(N))  begin errors++; $display("FAIL full_drop_cnt: got %0d expected %0d", bus.cnt_r, N); end
        if (bus.head_r.uid !== 8'd1)  begin errors++; $display("FAIL full_drop_head: got %0d expected 1", bus.head_r.uid); end
        for (int i = 0; i < 3; i++) begin
            drive_upd(1'b1, 0);
            tick();
        end
        drive_idle();
        for (int i = 17; i <= 19; i++) begin
            drive_push(i, 300, 7);
            tick();
        end
        drive_idle();
        checks += 1;
        if (bus.full_r !== 1'b1) begin errors++; $display("FAIL wrap_full: got %0b expected 1", bus.full_r); end
        for (int i = 4; i <= 19; i++) begin
            checks += 2;
            if (bus.head_vld_r !== 1'b1)  begin errors++; $display("FAIL drain_vld_%0d: got %0b expected 1", i, bus.head_vld_r); end
            if (bus.head_r.uid !== 8'(i)) begin errors++; $display("FAIL drain_uid: got %0d expected %0d", bus.head_r.uid, i); end
            drive_upd(1'b1, 0);
            tick();
        end
        drive_idle();
        checks += 2;
        if (bus.empty_r !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", bus.empty_r); end
        if (bus.cnt_r !== '0)     begin errors++; $display("FAIL drain_cnt: got %0d expected 0", bus.cnt_r); end
    endtask

    task automatic test_back_to_back();
        drive_push(7, 10, 3);
        tick();
        drive_push(8, 11, 6);
        drive_upd(1'b1, 0);
        tick();
        drive_idle();
        checks += 4;
        if (bus.head_vld_r !== 1'b1)      begin errors++; $display("FAIL bypass_vld: got %0b expected 1", bus.head_vld_r); end
        if (bus.head_r.uid !== 8'd8)      begin errors++; $display("FAIL bypass_uid: got %0d expected 8", bus.head_r.uid); end
        if (bus.head_r.quantity !== 16'd6) begin errors++; $display("FAIL bypass_qty: got %0d expected 6", bus.head_r.quantity); end
        if (bus.cnt_r !== W_CNT'(1))      begin errors++; $display("FAIL bypass_cnt: got %0d expected 1", bus.cnt_r); end
        drive_upd(1'b1, 0);
        tick();
        drive_idle();
        checks += 1;
        if (bus.empty_r !== 1'b1) begin errors++; $display("FAIL bypass_drain: got %0b expected 1", bus.empty_r); end
    endtask

    task automatic test_illegal_update();
        drive_upd(1'b0, 5);
        tick();
        drive_idle();
        checks += 2;
        if (bus.err_r !== 1'b1) begin errors++; $display("FAIL illegal_err: got %0b expected 1", bus.err_r); end
        if (bus.cnt_r !== '0)   begin errors++; $display("FAIL illegal_cnt: got %0d expected 0", bus.cnt_r); end
        tick();
        checks += 1;
        if (bus.err_r !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %0b expected 0", bus.err_r); end
        // Pointers untouched: next push/pop behaves normally.
        drive_push(42, 1, 2);
        tick();
        drive_idle();
        checks += 2;
        if (bus.head_r.uid !== 8'd42) begin errors++; $display("FAIL illegal_after_uid: got %0d expected 42", bus.head_r.uid); end
        if (bus.cnt_r !== W_CNT'(1))  begin errors++; $display("FAIL illegal_after_cnt: got %0d expected 1", bus.cnt_r); end
        drive_upd(1'b1, 0);
        tick();
        drive_idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive_push(20 + i, 5, 5);
            tick();
        end
        drive_idle();
        checks += 1;
        if (bus.cnt_r !== W_CNT'(5)) begin errors++; $display("FAIL areset_pre_cnt: got %0d expected 5", bus.cnt_r); end
        #2;
        rst = 1'b0;
        mq.delete();
        exp_err = 1'b0;
        #1;
        checks += 3;
        if (bus.head_vld_r !== 1'b0) begin errors++; $display("FAIL areset_vld: got %0b expected 0", bus.head_vld_r); end
        if (bus.cnt_r !== '0)        begin errors++; $display("FAIL areset_cnt: got %0d expected 0", bus.cnt_r); end
        if (bus.empty_r !== 1'b1)    begin errors++; $display("FAIL areset_empty: got %0b expected 1", bus.empty_r); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive_push(9, 1, 1);
        tick();
        drive_idle();
        checks += 3;
        if (bus.head_vld_r !== 1'b1) begin errors++; $display("FAIL areset_push_vld: got %0b expected 1", bus.head_vld_r); end
        if (bus.head_r.uid !== 8'd9) begin errors++; $display("FAIL areset_push_uid: got %0d expected 9", bus.head_r.uid); end
        if (bus.cnt_r !== W_CNT'(1)) begin errors++; $display("FAIL areset_push_cnt: got %0d expected 1", bus.cnt_r); end
    endtask

    task automatic test_random();
        ob_pkg::table_t exp_head;
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            if ($urandom_range(0, 99) < 55)
                drive_push($urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(1, 20));
            if ($urandom_range(0, 99) < 50)
                drive_upd(($urandom_range(0, 99) < 30), $urandom_range(0, 6));
            tick();
            exp_head = (mq.size() != 0) ? mq[0] : '0;
            checks += 6;
            if (bus.cnt_r !== W_CNT'(mq.size()))       begin errors++; $display("FAIL rnd_cnt @%0d: got %0d expected %0d", n, bus.cnt_r, mq.size()); end
            if (bus.head_vld_r !== (mq.size() != 0))   begin errors++; $display("FAIL rnd_vld @%0d: got %0b expected %0b", n, bus.head_vld_r, mq.size() != 0); end
            if (mq.size() != 0 && bus.head_r !== exp_head) begin errors++; $display("FAIL rnd_head @%0d: got %h expected %h", n, bus.head_r, exp_head); end
            if (bus.full_r !== (mq.size() == N))       begin errors++; $display("FAIL rnd_full @%0d: got %0b expected %0b", n, bus.full_r, mq.size() == N); end
            if (bus.empty_r !== (mq.size() == 0))      begin errors++; $display("FAIL rnd_empty @%0d: got %0b expected %0b", n, bus.empty_r, mq.size() == 0); end
            if (bus.err_r !== exp_err)                 begin errors++; $display("FAIL rnd_err @%0d: got %0b expected %0b", n, bus.err_r, exp_err); end
        end
        drive_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_push_empty();
        test_partial_fill();
        test_full_wrap();
        test_back_to_back();
        test_illegal_update();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
